// File: rtl/neptuno_spi_host.sv
// neptuno_spi_host: byte-oriented SPI mode-0 initiator for the user_io/data_io/OSD/SD selects
module neptuno_spi_host #(
  parameter int CLK_DIV = 4,
  parameter int CS_SETUP = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic [1:0] tx_sel,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SPI_SCK,
  output logic       SPI_DI,
  input  logic       SPI_DO,
  output logic       CONF_DATA0,
  output logic       SPI_SS2,
  output logic       SPI_SS3,
  output logic       SPI_SS4
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int SW = $clog2(2 * CS_SETUP + 1);
  localparam logic [HW-1:0] H_END = HW'(CLK_DIV - 1);
  localparam logic [SW-1:0] S_END = SW'(CS_SETUP - 1);
  localparam logic [SW-1:0] D_END = SW'(2 * CS_SETUP - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;
  state_t state, state_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic [SW-1:0] scnt, scnt_nx;
  logic [3:0] half, half_nx, cs_n, cs_nx;
  logic [7:0] sh, sh_nx, rx, rx_nx, rx_data_nx;
  logic last, last_nx, sck_nx, di_nx, rx_valid_nx, accept, half_end;
  assign tx_ready = !RESET && (state == IDLE || state == GAP);
  assign busy = state != IDLE;
  assign accept = tx_valid && tx_ready;
  assign half_end = hcnt == H_END;
  assign {SPI_SS4, SPI_SS3, SPI_SS2, CONF_DATA0} = cs_n;
  always_comb begin
    state_nx = state;
    hcnt_nx = hcnt;
    scnt_nx = scnt;
    half_nx = half;
    cs_nx = cs_n;
    sh_nx = sh;
    rx_nx = rx;
    rx_data_nx = rx_data;
    last_nx = last;
    sck_nx = SPI_SCK;
    di_nx = SPI_DI;
    rx_valid_nx = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nx = SETUP;
        scnt_nx = '0;
        sh_nx = tx_data;
        last_nx = tx_last;
        di_nx = tx_data[7];
        cs_nx = ~(4'b0001 << tx_sel);
      end
      SETUP: begin
        scnt_nx = scnt + 1'b1;
        hcnt_nx = '0;
        half_nx = '0;
        if (scnt == S_END) state_nx = SHIFT;
      end
      SHIFT: begin
        hcnt_nx = half_end ? '0 : hcnt + 1'b1;
        if (half_end) begin
          half_nx = half + 1'b1;
          sck_nx = !half[0];
          if (!half[0]) rx_nx = {rx[6:0], SPI_DO};
          else if (half == 4'd15) begin
            rx_valid_nx = 1'b1;
            rx_data_nx = rx;
            scnt_nx = '0;
            state_nx = last ? HOLD : GAP;
          end else begin
            sh_nx = {sh[6:0], 1'b0};
            di_nx = sh[6];
          end
        end
      end
      GAP: if (accept) begin
        state_nx = SHIFT;
        hcnt_nx = '0;
        half_nx = '0;
        sh_nx = tx_data;
        last_nx = tx_last;
        di_nx = tx_data[7];
      end
      HOLD: begin
        scnt_nx = scnt + 1'b1;
        cs_nx = scnt < S_END ? cs_n : 4'hf;
        if (scnt == D_END) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= IDLE;
      hcnt <= '0;
      scnt <= '0;
      half <= '0;
      cs_n <= 4'hf;
      sh <= '0;
      rx <= '0;
      rx_data <= '0;
      last <= 1'b0;
      SPI_SCK <= 1'b0;
      SPI_DI <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      state <= state_nx;
      hcnt <= hcnt_nx;
      scnt <= scnt_nx;
      half <= half_nx;
      cs_n <= cs_nx;
      sh <= sh_nx;
      rx <= rx_nx;
      rx_data <= rx_data_nx;
      last <= last_nx;
      SPI_SCK <= sck_nx;
      SPI_DI <= di_nx;
      rx_valid <= rx_valid_nx;
    end
  end
endmodule

// File: tb/tb_neptuno_spi_host.sv
// tb_neptuno_spi_host: directed and randomized-select checks of the SPI host against a mode-0 slave model
module tb_neptuno_spi_host;
  localparam int CSS = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [7:0] tx_data = 0, rx_data;
  logic [1:0] tx_sel = 0;
  logic tx_last = 0, tx_valid = 0, spi_do = 0;
  logic tx_ready, rx_valid, busy, sck, di, conf, ss2, ss3, ss4;
  logic [7:0] lb_data = 0, lb_rx_data;
  logic lb_valid = 0, lb_ready, lb_rx_valid, lb_busy, lb_sck, lb_di;
  logic [3:0] lb_cs;
  neptuno_spi_host #(.CLK_DIV(2), .CS_SETUP(CSS)) u_dut (
    .CLOCK_50(clk), .RESET(rst), .tx_data(tx_data), .tx_sel(tx_sel), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .SPI_SCK(sck), .SPI_DI(di), .SPI_DO(spi_do), .CONF_DATA0(conf),
    .SPI_SS2(ss2), .SPI_SS3(ss3), .SPI_SS4(ss4));
  neptuno_spi_host #(.CLK_DIV(1), .CS_SETUP(CSS)) u_lb (
    .CLOCK_50(clk), .RESET(rst), .tx_data(lb_data), .tx_sel(2'd1), .tx_last(1'b1),
    .tx_valid(lb_valid), .tx_ready(lb_ready), .rx_data(lb_rx_data), .rx_valid(lb_rx_valid),
    .busy(lb_busy), .SPI_SCK(lb_sck), .SPI_DI(lb_di), .SPI_DO(lb_di), .CONF_DATA0(lb_cs[0]),
    .SPI_SS2(lb_cs[1]), .SPI_SS3(lb_cs[2]), .SPI_SS4(lb_cs[3]));
  int n_checks = 0, n_fail = 0;
  int cyc = 0, hi_run = 100, multi_low = 0, short_gap = 0, sel_switch = 0, sel_bad = 0;
  int rx_cyc[$], acc_cyc[$], fall_cyc[$], rise_cyc[$], rdy_cyc[$], lb_rx_cyc[$], lb_acc[$], lb_rise[$];
  logic [7:0] rx_dat[$], lb_rx_dat[$];
  logic mosi_q[$];
  logic [1:0] fall_idx[$];
  logic [3:0] sn, prev_sn = 4'hf;
  logic [2:0] fb = 0;
  logic [1:0] acc_sel = 0;
  logic [7:0] slv_tx = 8'h3C;
  logic sck_prev = 0, rdy_prev = 0, lb_sck_prev = 0;
  function automatic logic [1:0] lo_idx(input logic [3:0] s);
    return !s[1] ? 2'd1 : !s[2] ? 2'd2 : !s[3] ? 2'd3 : 2'd0;
  endfunction
  // slave model and event log, evaluated mid-cycle when DUT outputs are settled
  always @(negedge clk) begin
    cyc++;
    sn = {ss4, ss3, ss2, conf};
    if (!$isunknown(sn)) begin
      if (sn == 4'hf) begin
        if (prev_sn != 4'hf) rise_cyc.push_back(cyc);
        hi_run++;
        fb = 0;
      end else begin
        if (prev_sn == 4'hf) begin
          fall_cyc.push_back(cyc);
          fall_idx.push_back(lo_idx(sn));
          if (hi_run < CSS) short_gap++;
          if (lo_idx(sn) != acc_sel) sel_bad++;
        end else if (sn != prev_sn) sel_switch++;
        if ($countones(~sn) > 1) multi_low++;
        hi_run = 0;
        if (sck && !sck_prev) mosi_q.push_back(di);
        if (!sck && sck_prev) fb++;
      end
      prev_sn = sn;
    end
    spi_do = slv_tx[~fb];
    if (rx_valid === 1'b1) begin rx_cyc.push_back(cyc); rx_dat.push_back(rx_data); end
    if (tx_valid && tx_ready === 1'b1) begin acc_cyc.push_back(cyc); if (!busy) acc_sel = tx_sel; end
    if (tx_ready === 1'b1 && !rdy_prev) rdy_cyc.push_back(cyc);
    rdy_prev = tx_ready === 1'b1;
    sck_prev = sck === 1'b1;
    if (lb_rx_valid === 1'b1) begin lb_rx_cyc.push_back(cyc); lb_rx_dat.push_back(lb_rx_data); end
    if (lb_valid && lb_ready === 1'b1) lb_acc.push_back(cyc);
    if (lb_sck === 1'b1 && !lb_sck_prev) lb_rise.push_back(cyc);
    lb_sck_prev = lb_sck === 1'b1;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [1:0] s, input logic [7:0] d, input logic l);
    @(posedge clk); #1;
    tx_sel = s; tx_data = d; tx_last = l; tx_valid = 1;
    for (int i = 0; i < 300; i++) begin @(negedge clk); if (tx_ready) break; end
    if (!tx_ready) check("accept_timeout", tx_ready, 1);
    @(posedge clk); #1;
    tx_valid = 0;
  endtask
  task automatic wait_rx(input int n);
    for (int i = 0; i < 3000 && rx_cyc.size() < n; i++) @(negedge clk);
    if (rx_cyc.size() < n) check("rx_timeout", rx_cyc.size(), n);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 500 && busy !== 1'b0; i++) @(negedge clk);
    if (busy !== 1'b0) check("idle_timeout", busy, 0);
  endtask
  function automatic logic [7:0] last8();
    logic [7:0] m = 0;
    for (int i = 0; i < 8; i++) m = {m[6:0], mosi_q[mosi_q.size() - 8 + i]};
    return m;
  endfunction
  int r0, f0, m0, l0, bad, nb, n;
  logic [1:0] s;
  logic [7:0] lbv [3] = '{8'h00, 8'hFF, 8'h81};
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", {ss4, ss3, ss2, conf}, 'hf);
    check("rst_sck", sck, 0);
    check("rst_di", di, 0);
    check("rst_rxv", rx_valid, 0);
    check("rst_rxd", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", tx_ready, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_rdy", tx_ready, 1);
    r0 = rx_cyc.size();
    send(2'd1, 8'hA5, 1);
    wait_rx(r0 + 1);
    wait_idle();
    repeat (5) @(negedge clk);
    check("sb_rx_lat", rx_cyc[r0] - acc_cyc[$], 35);
    check("sb_rx_data", rx_dat[r0], 8'h3C);
    check("sb_rx_count", rx_cyc.size() - r0, 1);
    check("sb_fall", fall_cyc[$] - acc_cyc[$], 1);
    check("sb_rise", rise_cyc[$] - acc_cyc[$], 37);
    check("sb_sel", fall_idx[$], 1);
    check("sb_mosi", last8(), 8'hA5);
    check("sb_ready", rdy_cyc[$] - acc_cyc[$], 39);
    r0 = rx_cyc.size(); f0 = fall_cyc.size();
    @(posedge clk); #1;
    tx_sel = 0; tx_last = 0; tx_data = 8'h14; tx_valid = 1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 300; i++) begin @(negedge clk); if (tx_ready) break; end
      if (!tx_ready) check("stream_timeout", tx_ready, 1);
      @(posedge clk); #1;
      tx_data = b == 0 ? 8'h00 : 8'hFF;
      tx_last = b == 1;
      if (b == 2) tx_valid = 0;
    end
    wait_rx(r0 + 3);
    wait_idle();
    check("mb_falls", fall_cyc.size() - f0, 1);
    check("mb_sel", fall_idx[$], 0);
    check("mb_first_lat", rx_cyc[r0] - acc_cyc[acc_cyc.size() - 3], 35);
    check("mb_gap1", rx_cyc[r0 + 1] - rx_cyc[r0], 33);
    check("mb_gap2", rx_cyc[r0 + 2] - rx_cyc[r0 + 1], 33);
    check("mb_rise", rise_cyc[$] - rx_cyc[r0 + 2], 2);
    check("mb_mosi", last8(), 8'hFF);
    r0 = rx_cyc.size(); f0 = fall_cyc.size();
    send(2'd2, 8'h55, 0);
    wait_rx(r0 + 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sck !== 1'b0 || ss3 !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b1) bad++;
    end
    check("gap_hold", bad, 0);
    send(2'd0, 8'hC3, 1);
    wait_rx(r0 + 2);
    wait_idle();
    check("gap_lat", rx_cyc[r0 + 1] - acc_cyc[$], 33);
    check("gap_falls", fall_cyc.size() - f0, 1);
    check("gap_sel", fall_idx[$], 2);
    check("gap_mosi", last8(), 8'hC3);
    r0 = rx_cyc.size(); m0 = mosi_q.size();
    send(2'd3, 8'h96, 1);
    for (int i = 0; i < 300 && mosi_q.size() - m0 < 4; i++) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("mid_rst_sel", {ss4, ss3, ss2, conf}, 'hf);
    check("mid_rst_sck", sck, 0);
    check("mid_rst_rxv", rx_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1 rst = 0;
    repeat (40) @(negedge clk);
    check("mid_rst_no_rx", rx_cyc.size() - r0, 0);
    slv_tx = 8'hA7;
    send(2'd3, 8'h5A, 1);
    wait_rx(r0 + 1);
    wait_idle();
    check("fresh_rx", rx_dat[r0], 8'hA7);
    check("fresh_mosi", last8(), 8'h5A);
    check("fresh_sel", fall_idx[$], 3);
    for (int k = 0; k < 3; k++) begin
      l0 = lb_rx_cyc.size();
      @(posedge clk); #1;
      lb_data = lbv[k]; lb_valid = 1;
      for (int i = 0; i < 300; i++) begin @(negedge clk); if (lb_ready) break; end
      @(posedge clk); #1 lb_valid = 0;
      for (int i = 0; i < 300 && lb_rx_cyc.size() <= l0; i++) @(negedge clk);
      if (lb_rx_cyc.size() <= l0) check("lb_timeout", lb_rx_cyc.size(), l0 + 1);
      else begin
        check("lb_data", lb_rx_dat[l0], lbv[k]);
        check("lb_lat", lb_rx_cyc[l0] - lb_acc[$], 19);
      end
      for (int i = 0; i < 300 && lb_busy !== 1'b0; i++) @(negedge clk);
    end
    check("lb_sck_period", lb_rise[$] - lb_rise[lb_rise.size() - 2], 2);
    slv_tx = 8'h69;
    r0 = rx_cyc.size(); nb = 0;
    repeat (25) begin
      s = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 3);
      for (int b = 0; b < n; b++) begin
        send(b == 0 ? s : 2'($urandom), 8'($urandom), b == n - 1);
        nb++;
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    wait_rx(r0 + nb);
    wait_idle();
    bad = 0;
    for (int i = r0; i < rx_cyc.size(); i++) if (rx_dat[i] != 8'h69) bad++;
    check("rand_bytes", rx_cyc.size() - r0, nb);
    check("rand_rx_data", bad, 0);
    check("excl_multi_low", multi_low, 0);
    check("excl_short_gap", short_gap, 0);
    check("excl_sel_switch", sel_switch, 0);
    check("excl_sel_bad", sel_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
